// File: rtl/shift_fifo_ctrl.sv
// Queue controller for a 32-entry addressable shift-register FIFO: tracks occupancy,
// always fetches the oldest entry and presents it on a valid/ready pop port.
// Optional saturating drop counter enabled by defining SHIFT_FIFO_CTRL_DROPCNT_EN.
module shift_fifo_ctrl #(
    parameter int DW    = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_valid,
    input  logic [DW-1:0] push_data,
    output logic          push_ready,
    output logic          pop_valid,
    output logic [DW-1:0] pop_data,
    input  logic          pop_ready,
    input  logic          flush,
    input  logic          ovf_clr,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          ovf,
`ifdef SHIFT_FIFO_CTRL_DROPCNT_EN
    output logic [7:0]    drop_cnt,
`endif
    output logic          fifo_wea,
    output logic [DW-1:0] fifo_din,
    output logic [AW-1:0] fifo_addr,
    input  logic [DW-1:0] fifo_dout
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE        = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_AW     = AW'(1);

    state_t        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic          pop_valid_q, pop_valid_d;
    logic [DW-1:0] pop_data_q, pop_data_d;
    logic          ovf_q, ovf_d;

    logic          push_fire;
    logic          read_issue;
    logic          drop;
    logic [AW-1:0] count_lo;

    assign full       = (count_q == FULL_COUNT);
    assign empty      = (count_q == '0);
    assign push_ready = !full;
    assign count      = count_q;
    assign pop_valid  = pop_valid_q;
    assign pop_data   = pop_data_q;
    assign ovf        = ovf_q;

    assign push_fire  = push_valid & push_ready;
    assign drop       = push_valid & full;
    assign read_issue = (state_q == IDLE) && (count_q != '0) && !flush;
    assign count_lo   = count_q[AW-1:0];

    assign fifo_wea = push_fire & !flush;
    assign fifo_din = push_data;

    // A push in the issue cycle shifts the oldest entry up by one slot, so read one higher.
    // With count == DEPTH the low bits wrap to 0 and 0 - 1 lands on DEPTH-1 as required.
    always_comb begin
        fifo_addr = '0;
        if (read_issue) begin
            fifo_addr = push_fire ? count_lo : (count_lo - ONE_AW);
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        pop_valid_d = pop_valid_q;
        pop_data_d  = pop_data_q;
        ovf_d       = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

        if (push_fire && !read_issue) begin
            count_d = count_q + ONE;
        end else if (!push_fire && read_issue) begin
            count_d = count_q - ONE;
        end

        case (state_q)
            IDLE: begin
                if (read_issue) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                pop_data_d  = fifo_dout;
                pop_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (pop_ready) begin
                    pop_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush leaves stale words in the FIFO; zero count makes them unreachable.
        if (flush) begin
            state_d     = IDLE;
            count_d     = '0;
            pop_valid_d = 1'b0;
            pop_data_d  = pop_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            pop_valid_q <= 1'b0;
            pop_data_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pop_valid_q <= pop_valid_d;
            pop_data_q  <= pop_data_d;
            ovf_q       <= ovf_d;
        end
    end

`ifdef SHIFT_FIFO_CTRL_DROPCNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // A drop coinciding with a clear counts as the first drop after the clear.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (ovf_clr) begin
            drop_cnt_d = drop ? 8'd1 : 8'd0;
        end else if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_shift_fifo_ctrl.sv
// Bench for shift_fifo_ctrl: behavioural shift-register FIFO plus a queue-based
// reference model; directed scenarios followed by randomized traffic.
module tb_shift_fifo_ctrl;
    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          push_valid = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic          push_ready;
    logic          pop_valid;
    logic [DW-1:0] pop_data;
    logic          pop_ready = 1'b0;
    logic          flush = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          ovf;
`ifdef SHIFT_FIFO_CTRL_DROPCNT_EN
    logic [7:0]    drop_cnt;
`endif
    logic          fifo_wea;
    logic [DW-1:0] fifo_din;
    logic [AW-1:0] fifo_addr;
    logic [DW-1:0] fifo_dout = '0;

    always #5 clk = ~clk;

    shift_fifo_ctrl #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
        .pop_valid(pop_valid), .pop_data(pop_data), .pop_ready(pop_ready),
        .flush(flush), .ovf_clr(ovf_clr),
        .count(count), .full(full), .empty(empty), .ovf(ovf),
`ifdef SHIFT_FIFO_CTRL_DROPCNT_EN
        .drop_cnt(drop_cnt),
`endif
        .fifo_wea(fifo_wea), .fifo_din(fifo_din), .fifo_addr(fifo_addr),
        .fifo_dout(fifo_dout)
    );

    // Shift-register FIFO: newest at index 0, registered read of post-shift contents.
    logic [DW-1:0] mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (fifo_wea) begin
            for (int i = DEPTH-1; i > 0; i--) mem[i] <= mem[i-1];
            mem[0] <= fifo_din;
        end
        if (fifo_wea) fifo_dout <= (fifo_addr == 0) ? fifo_din : mem[fifo_addr-1];
        else          fifo_dout <= mem[fifo_addr];
    end

    // Reference model: queue of stored words, one word in flight, one word held.
    logic [DW-1:0] mq [$];
    bit            m_inflight;
    logic [DW-1:0] m_inflight_data;
    bit            m_held_valid;
    logic [DW-1:0] m_held_data;
    bit            m_ovf;
    int            m_drop;

    int errors = 0;
    int checks = 0;
    int exp_addr = -1;
    logic [DW-1:0] got [$];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit push_ok, drop, busy, issue;
        if (rst) begin
            mq.delete();
            m_inflight = 0; m_held_valid = 0; m_held_data = '0;
            m_ovf = 0; m_drop = 0;
            return;
        end
        push_ok = push_valid && (mq.size() < DEPTH);
        drop    = push_valid && (mq.size() == DEPTH);
        busy    = m_inflight || m_held_valid;
        issue   = !busy && (mq.size() > 0) && !flush;
        m_ovf   = drop ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
        if (ovf_clr) m_drop = drop ? 1 : 0;
        else if (drop && m_drop < 255) m_drop++;
        if (flush) begin
            mq.delete();
            m_inflight = 0;
            m_held_valid = 0;
        end else begin
            if (m_inflight) begin
                m_held_data = m_inflight_data;
                m_held_valid = 1;
                m_inflight = 0;
            end else if (m_held_valid && pop_ready) begin
                $display("pop data=%08h", m_held_data);
                m_held_valid = 0;
            end
            if (issue) begin
                m_inflight = 1;
                m_inflight_data = mq.pop_front();
            end
            if (push_ok) mq.push_back(push_data);
        end
    endtask

    // One clock: check combinational FIFO drive, advance model, check registered outputs.
    task automatic cycle();
        bit exp_wea;
        @(negedge clk);
        exp_wea = push_valid && (mq.size() < DEPTH) && !flush;
        check_val("fifo_wea", fifo_wea, exp_wea);
        if (exp_wea) check_val("fifo_din", fifo_din, push_data);
        if (exp_addr >= 0) check_val("fifo_addr", fifo_addr, exp_addr);
        model_step();
        @(posedge clk);
        #1;
        check_val("pop_valid", pop_valid, m_held_valid);
        check_val("pop_data", pop_data, m_held_data);
        check_val("count", count, mq.size());
        check_val("full", full, mq.size() == DEPTH);
        check_val("empty", empty, mq.size() == 0);
        check_val("push_ready", push_ready, mq.size() != DEPTH);
        check_val("ovf", ovf, m_ovf);
`ifdef SHIFT_FIFO_CTRL_DROPCNT_EN
        check_val("drop_cnt", drop_cnt, m_drop);
`endif
    endtask

    task automatic idle_inputs();
        push_valid = 0; pop_ready = 0; flush = 0; ovf_clr = 0; rst = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        cycle();
        rst = 0;
        cycle();
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        push_valid = 1; push_data = d;
        cycle();
        push_valid = 0;
    endtask

    task automatic drain(input int n);
        got.delete();
        push_valid = 0; pop_ready = 1;
        for (int i = 0; i < n; i++) begin
            if (pop_valid) got.push_back(pop_data);
            cycle();
        end
        pop_ready = 0;
    endtask

    initial begin
        int n;
        int push_pct, pop_pct;

        // Reset state
        do_reset();
        check_val("rst_empty", empty, 1);
        check_val("rst_push_ready", push_ready, 1);

        // Three back-to-back pushes, consumer stalled
        push_word(32'hA1); push_word(32'hB2); push_word(32'hC3);
        check_val("t1_valid", pop_valid, 1);
        check_val("t1_data", pop_data, 32'hA1);
        check_val("t1_count", count, 2);
        drain(12);
        check_val("t1_npop", got.size(), 3);
        if (got.size() == 3) begin
            check_val("t1_pop1", got[1], 32'hB2);
            check_val("t1_pop2", got[2], 32'hC3);
        end
        check_val("t1_empty", empty, 1);

        // Fill until full, overflow behaviour, drain in order
        do_reset();
        n = 0;
        while (push_ready && n < 40) begin
            push_word(n);
            n++;
        end
        check_val("t2_accepted", n, DEPTH + 1);
        check_val("t2_full", full, 1);
        check_val("t2_push_ready", push_ready, 0);
        push_word(32'hDEAD);
        check_val("t2_ovf", ovf, 1);
        check_val("t2_count", count, DEPTH);
        push_valid = 1; ovf_clr = 1; cycle();
        push_valid = 0; ovf_clr = 0;
        check_val("t2_ovf_setwins", ovf, 1);
`ifdef SHIFT_FIFO_CTRL_DROPCNT_EN
        check_val("t2_drop_cnt", drop_cnt, 1);
`endif
        ovf_clr = 1; cycle(); ovf_clr = 0;
        check_val("t2_ovf_clr", ovf, 0);
        drain(120);
        check_val("t2_npop", got.size(), DEPTH + 1);
        for (int i = 0; i < got.size(); i++) check_val("t2_order", got[i], i);

        // Push in the same cycle as read issue with count=5
        do_reset();
        for (int i = 0; i < 6; i++) push_word(32'h10 + i);
        check_val("t3_count_hold", count, 5);
        pop_ready = 1; cycle(); pop_ready = 0;
        exp_addr = 5;
        push_word(32'h55);
        exp_addr = -1;
        check_val("t3_count", count, 5);
        cycle();
        check_val("t3_data", pop_data, 32'h11);

        // Flush while holding with count=4
        do_reset();
        for (int i = 0; i < 5; i++) push_word(32'h20 + i);
        check_val("t4_count", count, 4);
        flush = 1; cycle(); flush = 0;
        check_val("t4_valid", pop_valid, 0);
        check_val("t4_empty", empty, 1);
        push_word(32'h77);
        drain(8);
        check_val("t4_npop", got.size(), 1);
        if (got.size() == 1) check_val("t4_data", got[0], 32'h77);

        // Reset while fetching with count=3
        do_reset();
        for (int i = 0; i < 5; i++) push_word(32'h30 + i);
        pop_ready = 1; cycle(); pop_ready = 0;
        cycle();
        check_val("t5_count", count, 3);
        rst = 1; cycle(); rst = 0;
        check_val("t5_pop_data", pop_data, 0);
        check_val("t5_count0", count, 0);
        push_word(32'h99);
        drain(8);
        check_val("t5_npop", got.size(), 1);
        if (got.size() == 1) check_val("t5_data", got[0], 32'h99);

        // Randomized traffic with varying push/pop pressure
        for (int seg = 0; seg < 4; seg++) begin
            case (seg)
                0: begin push_pct = 50; pop_pct = 50; end
                1: begin push_pct = 90; pop_pct = 10; end
                2: begin push_pct = 20; pop_pct = 90; end
                default: begin push_pct = 70; pop_pct = 40; end
            endcase
            for (int c = 0; c < 500; c++) begin
                push_valid = ($urandom_range(0, 99) < push_pct);
                push_data  = $urandom;
                pop_ready  = ($urandom_range(0, 99) < pop_pct);
                flush      = ($urandom_range(0, 59) == 0);
                ovf_clr    = ($urandom_range(0, 29) == 0);
                rst        = ($urandom_range(0, 499) == 0);
                cycle();
            end
        end
        idle_inputs();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
